// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM states and the iteration count.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned ITERS    = MD_WIDTH;
   localparam int unsigned CNT_W    = $clog2(ITERS);

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // Bit 1 of the op code selects divide, bit 0 selects signed.
   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction for the multiply/divide unit. Takes the unsigned
// magnitude result pair and applies the negations the signed ops need:
// MULT negates the whole 64-bit product, DIV negates the quotient and
// gives the remainder the sign of the dividend.
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  op_e              op,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic [WIDTH-1:0] raw_hi,
   input  logic [WIDTH-1:0] raw_lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_neg;

   // Select raw or negated halves according to the operation and captured signs.
   always_comb begin
      prod     = {raw_hi, raw_lo};
      prod_neg = '0 - prod;
      hi       = raw_hi;
      lo       = raw_lo;
      case (op)
         OP_MULT: begin
            if (sign_a ^ sign_b) begin
               hi = prod_neg[2*WIDTH-1:WIDTH];
               lo = prod_neg[WIDTH-1:0];
            end
         end
         OP_DIV: begin
            if (sign_a ^ sign_b) lo = '0 - raw_lo;
            if (sign_a)          hi = '0 - raw_hi;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV) writing HI/LO.
// One shift-add or restoring shift-subtract step per clock, 32 steps, then a
// sign-fix cycle. Optional build macro MULDIV_FAST_ZERO_EN lets zero-operand
// multiplies and divide-by-zero skip straight to the fix cycle.
module iter_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   state_e           state_q, state_d;
   logic             capture, step, fix;

   op_e              op_in;
   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   op_e              op_q;
   logic             sign_a_q, sign_b_q, div0_q;
   logic [WIDTH-1:0] a_raw_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULDIV_FAST_ZERO_EN
   logic             a_zero, short_path;
`endif

   // Operand decode: magnitudes for signed ops and zero detection.
   always_comb begin
      op_in  = op_e'(OP);
      a_neg  = op_is_signed(op_in) & A[WIDTH-1];
      b_neg  = op_is_signed(op_in) & B[WIDTH-1];
      a_mag  = a_neg ? ('0 - A) : A;
      b_mag  = b_neg ? ('0 - B) : B;
      b_zero = (B == '0);
`ifdef MULDIV_FAST_ZERO_EN
      a_zero     = (A == '0);
      short_path = op_is_div(op_in) ? b_zero : (a_zero | b_zero);
`endif
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-state datapath strobes.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               capture = 1'b1;
               state_d = ST_CALC;
`ifdef MULDIV_FAST_ZERO_EN
               if (short_path) state_d = ST_FIX;
`endif
            end
         end
         ST_CALC: begin
            step = 1'b1;
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            fix     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // One iteration of each algorithm. Multiply keeps the multiplier in
   // acc_lo and shifts product bits in from the top; divide shifts the
   // dividend out of acc_lo into the partial remainder in acc_hi, and the
   // borrow bit of the trial subtraction decides the quotient bit.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, dvs_q};
      div_ge    = ~div_diff[WIDTH];
   end

   muldiv_signfix #(
      .WIDTH (WIDTH)
   ) u_signfix (
      .op     (op_q),
      .sign_a (sign_a_q),
      .sign_b (sign_b_q),
      .raw_hi (acc_hi_q),
      .raw_lo (acc_lo_q),
      .hi     (fix_hi),
      .lo     (fix_lo)
   );

   // Operand capture, iteration datapath, and HI/LO write-back at FIX.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q     <= OP_MULTU;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         div0_q   <= 1'b0;
         a_raw_q  <= '0;
         dvs_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= fix;
         if (capture) begin
            op_q     <= op_in;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            div0_q   <= op_is_div(op_in) & b_zero;
            a_raw_q  <= A;
            dvs_q    <= b_mag;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            cnt_q    <= '0;
`ifdef MULDIV_FAST_ZERO_EN
            // Skipping the iterations: a zero accumulator already is the product.
            if (short_path) acc_lo_q <= '0;
`endif
         end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            if (op_is_div(op_q)) begin
               acc_hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
               acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
               acc_hi_q <= mul_sum[WIDTH:1];
               acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
         end
         if (fix) begin
            hi_q <= div0_q ? a_raw_q : fix_hi;
            lo_q <= div0_q ? '1      : fix_lo;
         end
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_iter_muldiv;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [1:0]  OP;
   logic [31:0] A, B;
   logic        BUSY, DONE;
   logic [31:0] HI, LO;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   iter_muldiv dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .OP    (OP),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .HI    (HI),
      .LO    (LO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result {HI,LO} from plain arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (op)
         2'd0: p = {32'd0, a} * {32'd0, b};
         2'd1: p = sa * sb;
         2'd2: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else        p = {a % b, a / b};
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   // Cycles from the START cycle to the DONE cycle.
   function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
      if (op[1] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Called at a falling edge: present a request for the next rising edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      OP    = op;
      A     = a;
      B     = b;
      START = 1'b1;
   endtask

   // Wait for DONE, checking BUSY and HI/LO hold on the way; optionally
   // pulse a competing START with A=B=1 at cycle pulse_at.
   task automatic wait_done(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int pulse_at);
      logic [63:0] exp;
      int          lat;
      int          cyc;
      bit          seen;
      exp  = model(op, a, b);
      lat  = exp_latency(op, a, b);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 60) begin
         @(negedge CLK);
         cyc++;
         if (DONE) seen = 1;
         else begin
            chk("busy_in_flight", 64'(BUSY), 64'd1);
            chk("hilo_hold", {HI, LO}, {exp_hi, exp_lo});
         end
         if (cyc == 1) begin
            START = 1'b0;
            OP    = 2'($urandom_range(0, 3));
            A     = $urandom;
            B     = $urandom;
         end
         if (pulse_at > 0 && cyc == pulse_at) begin
            START = 1'b1;
            OP    = 2'd0;
            A     = 32'd1;
            B     = 32'd1;
         end
         if (pulse_at > 0 && cyc == pulse_at + 1) START = 1'b0;
      end
      chk("latency", 64'(cyc), 64'(lat));
      chk("busy_at_done", 64'(BUSY), 64'd0);
      chk("result", {HI, LO}, exp);
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at);
      issue(op, a, b);
      wait_done(op, a, b, pulse_at);
      @(negedge CLK);
      chk("done_one_cycle", 64'(DONE), 64'd0);
      chk("idle_after", 64'(BUSY), 64'd0);
   endtask

   initial begin
      int n_done;
      RST   = 1'b1;
      START = 1'b0;
      OP    = 2'd0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge CLK);
      chk("reset_busy", 64'(BUSY), 64'd0);
      chk("reset_done", 64'(DONE), 64'd0);
      chk("reset_hilo", {HI, LO}, 64'd0);
      RST = 1'b0;
      @(negedge CLK);

      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0);
      chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'd2, 32'd100, 32'd7, 0);
      chk("divu_basic", {HI, LO}, 64'h0000_0002_0000_000E);
      run_op(2'd2, 32'd5, 32'd0, 0);
      chk("divu_by_zero", {HI, LO}, 64'h0000_0005_FFFF_FFFF);
      run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);

      // Abort mid-operation with a competing START before the reset.
      issue(2'd0, 32'd6, 32'd7);
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         chk("abort_busy", 64'(BUSY), 64'd1);
         chk("abort_no_done", 64'(DONE), 64'd0);
         if (c == 1) START = 1'b0;
         if (c == 5) begin
            START = 1'b1;
            A     = 32'd1;
            B     = 32'd1;
         end
         if (c == 6) START = 1'b0;
      end
      #2 RST = 1'b1;
      #1;
      chk("async_rst_busy", 64'(BUSY), 64'd0);
      chk("async_rst_done", 64'(DONE), 64'd0);
      chk("async_rst_hilo", {HI, LO}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge CLK);
      RST    = 1'b0;
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (DONE) n_done++;
      end
      chk("no_done_after_rst", 64'(n_done), 64'd0);
      chk("idle_after_rst", 64'(BUSY), 64'd0);

      // Same sequence without reset: the competing START must be ignored.
      run_op(2'd0, 32'd6, 32'd7, 5);
      chk("ignore_start", {HI, LO}, 64'd42);

      // Back-to-back: new request accepted in the DONE cycle.
      issue(2'd0, 32'd9, 32'd11);
      wait_done(2'd0, 32'd9, 32'd11, 0);
      issue(2'd0, 32'd2, 32'd3);
      wait_done(2'd0, 32'd2, 32'd3, 0);
      chk("b2b_result", {HI, LO}, 64'd6);
      @(negedge CLK);
      chk("b2b_done_one_cycle", 64'(DONE), 64'd0);

      run_op(2'd1, 32'd0, 32'd12345, 0);
      chk("mult_zero", {HI, LO}, 64'd0);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = pick();
         run_op(rop, ra, rb, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Iterative 32-bit multiply/divide unit for the simple CPU. It sits directly downstream of the ALU operand-B 2:1 32-bit mux.
- A comes from the register-file port; B is the mux output Y.
- Computes MULT/MULTU/DIV/DIVU over multiple cycles into HI/LO holding registers. The control unit stalls on BUSY.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported by the CPU.
- ITERS, WIDTH, iteration count in CALC. Derived; not overridden.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  request; sampled only in IDLE
- OP  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  32  operand A (rs)
- B  in  32  operand B (operand-mux output)
- BUSY  out  1  high while an operation is in flight
- DONE  out  1  one-cycle pulse when HI/LO are updated
- HI  out  32  product high word / remainder
- LO  out  32  product low word / quotient

Behaviour:
- Reset (async, RST=1): state IDLE; BUSY=0, DONE=0, HI=0, LO=0; internal accumulators cleared. Reset mid-operation aborts it; no partial HI/LO update.
- States:
  - IDLE: START=1 at edge 0 captures OP, A, B and operand signs (signed ops use |A|, |B|); goes to CALC with counter=0.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per edge. Runs edges 1..32; after counter reaches 31 it goes to FIX.
  - FIX: edge 33 applies sign correction, writes HI/LO, goes to IDLE.
- Outputs by cycle:
  - BUSY=1 from after edge 0 until edge 33.
  - DONE=1 for exactly the cycle after edge 33.
  - HI/LO change only at the FIX edge and otherwise hold.
- START while BUSY=1 is ignored; operands are not re-captured. START during the DONE cycle (state IDLE) is accepted.
- Multiply: 64-bit product {HI,LO}. For MULT, the product is negated when sign(A)^sign(B).
- Divide:
  - LO = quotient, HI = remainder.
  - For DIV, the quotient is negated when sign(A)^sign(B); the remainder takes the sign of A.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero (B=0, DIVU or DIV): LO=0xFFFFFFFF, HI=A raw. No sign fix is applied; latency is unchanged.
- A and B may change freely after edge 0.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: at edge 0, if either operand is 0 (MULT/MULTU) or B=0 (DIV/DIVU), go directly to FIX. FIX occurs at edge 1 and DONE is high in the following cycle. Results are identical to the full path.
- Undefined: every operation takes exactly 33 edges after capture.

Decomposition:
- Shared package muldiv_pkg holds:
  - OP encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state encoding (ST_IDLE, ST_CALC, ST_FIX)
  - ITERS constant
- One natural sub-module, muldiv_signfix: combinational abs/negate of the 64-bit result pair, selected by OP and the captured signs. The FSM and iteration datapath stay in iter_muldiv.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DONE high exactly in the cycle after edge 33; BUSY low in that cycle.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002.
- DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=0x00000005.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULTU 6*7, pulse START with A=1, B=1 at CALC cycle 5, then assert RST at CALC cycle 20:
  - Before reset, the second START is ignored.
  - On RST, BUSY=0, DONE=0, HI=LO=0 asynchronously, with no DONE afterwards.
  - A repeat without reset gives HI=0, LO=42.
- Back-to-back: assert START with MULTU 2*3 during the DONE cycle of a prior op -> accepted; second DONE 34 cycles later with LO=6.
  - With MULDIV_FAST_ZERO_EN, MULT 0*B gives DONE in the cycle after edge 1 and HI=LO=0.
